clock_display_scan: RTL and testbench

Downstream display stage for the digital clock block. It takes the binary hour/minute/second counts and converts them to BCD with a sequential double-dabble FSM. It then time-multiplexes six 7-segment digits (HH MM SS). In setting mode it blanks the field selected by set_pos during the low phase of the 2 Hz blink, giving the edit-cursor flash.

---
 rtl/clock_disp_pkg.sv | 53 +++++
 rtl/bcd6_dabble.sv | 51 +++++
 rtl/clock_display_scan.sv | 191 +++++++++++++++++++
 tb/tb_clock_display_scan.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_disp_pkg.sv
// Shared types and constants for the clock display stage: conversion FSM states,
// 7-segment table, digit indices and the field-to-set_pos bit mapping.
package clock_disp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } conv_state_e;

   typedef struct packed {
      logic [4:0] hour;
      logic [5:0] min;
      logic [5:0] sec;
   } time_t;

   localparam int unsigned NUM_DIGITS  = 6;
   localparam int unsigned BIN_W       = 6;
   localparam int unsigned SHIFT_STEPS = 6;

   localparam logic [2:0] DIG_SEC_U  = 3'd0;
   localparam logic [2:0] DIG_SEC_T  = 3'd1;
   localparam logic [2:0] DIG_MIN_U  = 3'd2;
   localparam logic [2:0] DIG_MIN_T  = 3'd3;
   localparam logic [2:0] DIG_HOUR_U = 3'd4;
   localparam logic [2:0] DIG_HOUR_T = 3'd5;

   // Same position encoding the clock block uses for set_pos.
   localparam logic [1:0] FIELD_SEC  = 2'd0;
   localparam logic [1:0] FIELD_MIN  = 2'd1;
   localparam logic [1:0] FIELD_HOUR = 2'd2;

   // Active-high {g,f,e,d,c,b,a}, entry 0 in the low bits.
   localparam logic [9:0][6:0] SEG_LUT = {
      7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
      7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   function automatic logic [6:0] seg_encode(input logic [3:0] digit);
      seg_encode = 7'h00;
      if (digit <= 4'd9) seg_encode = SEG_LUT[digit];
   endfunction

   function automatic logic [1:0] digit_field(input logic [2:0] idx);
      case (idx)
         DIG_SEC_U, DIG_SEC_T: digit_field = FIELD_SEC;
         DIG_MIN_U, DIG_MIN_T: digit_field = FIELD_MIN;
         default:              digit_field = FIELD_HOUR;
      endcase
   endfunction

endpackage

// File: rtl/bcd6_dabble.sv
// Sequential 6-bit binary to two-digit BCD converter (shift-and-add-3),
// sequenced externally by load/step/done strobes.
module bcd6_dabble
   import clock_disp_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             done,
   input  logic [BIN_W-1:0] bin_in,
   output logic [3:0]       tens,
   output logic [3:0]       units
);

   logic [BIN_W-1:0] bin_q;
   logic [7:0]       bcd_q;
   logic [7:0]       bcd_adj_c;

   // Add 3 to any nibble that would overflow decimal after the next shift.
   always_comb begin
      bcd_adj_c = bcd_q;
      if (bcd_q[3:0] >= 4'd5) bcd_adj_c[3:0] = bcd_q[3:0] + 4'd3;
      if (bcd_q[7:4] >= 4'd5) bcd_adj_c[7:4] = bcd_q[7:4] + 4'd3;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bin_q <= '0;
         bcd_q <= '0;
      end else if (load) begin
         bin_q <= bin_in;
         bcd_q <= '0;
      end else if (step) begin
         bcd_q <= {bcd_adj_c[6:0], bin_q[BIN_W-1]};
         bin_q <= {bin_q[BIN_W-2:0], 1'b0};
      end
   end

   // Visible digits only change on done, so a partial result is never shown.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tens  <= '0;
         units <= '0;
      end else if (done) begin
         tens  <= bcd_q[7:4];
         units <= bcd_q[3:0];
      end
   end

endmodule

// File: rtl/clock_display_scan.sv
// Clock display stage: synchronizes time/setting inputs, converts to BCD on change
// and scans six multiplexed 7-segment digits with edit-cursor blanking.
module clock_display_scan
   import clock_disp_pkg::*;
#(
   parameter int unsigned CLK_HZ       = 50_000_000,
   parameter int unsigned SCAN_HZ      = 1000,
   parameter bit          COMMON_ANODE = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4:0]            hour_in,
   input  logic [5:0]            min_in,
   input  logic [5:0]            sec_in,
   input  logic                  mode,
   input  logic [2:0]            set_pos,
   input  logic                  blink_en,
   output logic [6:0]            seg_out,
   output logic                  dp_out,
   output logic [NUM_DIGITS-1:0] dig_sel,
   output logic                  busy
);

   localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
   localparam int unsigned PRE_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned STEP_W   = 3;
   localparam logic        ACT_INV  = COMMON_ANODE;

   time_t       time_m, time_s, time_p, snap_q, last_q;
   logic        mode_m, mode_s, blink_m, blink_s;
   logic [2:0]  set_pos_m, set_pos_s;

   conv_state_e         state_q, state_d;
   logic [STEP_W-1:0]   step_q;
   logic                load_c, step_c, done_c, stable_c;

   logic [3:0]  sec_t, sec_u, min_t, min_u, hour_t, hour_u;

   logic [PRE_W-1:0]      pre_q;
   logic [2:0]            idx_q;
   logic [3:0]            digit_c;
   logic                  blank_c;
   logic [6:0]            seg_c;
   logic                  dp_c;
   logic [NUM_DIGITS-1:0] sel_c;

   // Two-flop synchronizers plus one extra time stage for the stability compare.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         time_m    <= '0;
         time_s    <= '0;
         time_p    <= '0;
         mode_m    <= 1'b0;
         mode_s    <= 1'b0;
         blink_m   <= 1'b0;
         blink_s   <= 1'b0;
         set_pos_m <= '0;
         set_pos_s <= '0;
      end else begin
         time_m    <= {hour_in, min_in, sec_in};
         time_s    <= time_m;
         time_p    <= time_s;
         mode_m    <= mode;
         mode_s    <= mode_m;
         blink_m   <= blink_en;
         blink_s   <= blink_m;
         set_pos_m <= set_pos;
         set_pos_s <= set_pos_m;
      end
   end

   assign stable_c = (time_s == time_p);

   always_comb begin
      state_d = state_q;
      load_c  = 1'b0;
      step_c  = 1'b0;
      done_c  = 1'b0;
      case (state_q)
         ST_IDLE:  if (stable_c && (time_s != last_q)) state_d = ST_LOAD;
         ST_LOAD: begin
            load_c  = 1'b1;
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            step_c = 1'b1;
            if (step_q == STEP_W'(SHIFT_STEPS - 1)) state_d = ST_DONE;
         end
         ST_DONE: begin
            done_c  = 1'b1;
            state_d = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         busy    <= 1'b0;
         step_q  <= '0;
         snap_q  <= '0;
         last_q  <= '0;
      end else begin
         state_q <= state_d;
         busy    <= (state_d != ST_IDLE);
         if (load_c) begin
            step_q <= '0;
            snap_q <= time_s;
         end else if (step_c) begin
            step_q <= step_q + STEP_W'(1);
         end
         if (done_c) last_q <= snap_q;
      end
   end

   bcd6_dabble u_sec (
      .clk    (clk),
      .reset  (reset),
      .load   (load_c),
      .step   (step_c),
      .done   (done_c),
      .bin_in (time_s.sec),
      .tens   (sec_t),
      .units  (sec_u)
   );

   bcd6_dabble u_min (
      .clk    (clk),
      .reset  (reset),
      .load   (load_c),
      .step   (step_c),
      .done   (done_c),
      .bin_in (time_s.min),
      .tens   (min_t),
      .units  (min_u)
   );

   bcd6_dabble u_hour (
      .clk    (clk),
      .reset  (reset),
      .load   (load_c),
      .step   (step_c),
      .done   (done_c),
      .bin_in ({1'b0, time_s.hour}),
      .tens   (hour_t),
      .units  (hour_u)
   );

   // Scan prescaler and digit index.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_q <= '0;
         idx_q <= DIG_SEC_U;
      end else if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
         pre_q <= '0;
         idx_q <= (idx_q == DIG_HOUR_T) ? DIG_SEC_U : idx_q + 3'd1;
      end else begin
         pre_q <= pre_q + PRE_W'(1);
      end
   end

   always_comb begin
      case (idx_q)
         DIG_SEC_U:  digit_c = sec_u;
         DIG_SEC_T:  digit_c = sec_t;
         DIG_MIN_U:  digit_c = min_u;
         DIG_MIN_T:  digit_c = min_t;
         DIG_HOUR_U: digit_c = hour_u;
         default:    digit_c = hour_t;
      endcase
      blank_c = mode_s && !blink_s && set_pos_s[digit_field(idx_q)];
      seg_c   = blank_c ? 7'h00 : seg_encode(digit_c);
      dp_c    = !blank_c && ((idx_q == DIG_MIN_U) || (idx_q == DIG_HOUR_U));
      sel_c   = NUM_DIGITS'(1) << idx_q;
   end

   // All display outputs registered together from the same index.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         seg_out <= {7{ACT_INV}};
         dp_out  <= ACT_INV;
         dig_sel <= {NUM_DIGITS{ACT_INV}};
      end else begin
         seg_out <= seg_c ^ {7{ACT_INV}};
         dp_out  <= dp_c ^ ACT_INV;
         dig_sel <= sel_c ^ {NUM_DIGITS{ACT_INV}};
      end
   end

endmodule

// File: tb/tb_clock_display_scan.sv
// Scoreboard bench for clock_display_scan: expected scan frames are queued by the
// stimulus and compared by a scan monitor as the DUT walks the six digits.
module tb_clock_display_scan;

   localparam int unsigned SCAN_DIV = 10;

   typedef struct packed {
      logic [5:0][6:0] seg;
      logic [5:0]      dp;
   } frame_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] hour_in;
   logic [5:0] min_in;
   logic [5:0] sec_in;
   logic       mode;
   logic [2:0] set_pos;
   logic       blink_en;
   logic [6:0] seg_out;
   logic       dp_out;
   logic [5:0] dig_sel;
   logic       busy;

   frame_t exp_q[$];
   int tests = 0;
   int fails = 0;
   int busy_rises = 0;

   always #5 clk = ~clk;

   clock_display_scan #(
      .CLK_HZ       (1000),
      .SCAN_HZ      (100),
      .COMMON_ANODE (1'b1)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .hour_in  (hour_in),
      .min_in   (min_in),
      .sec_in   (sec_in),
      .mode     (mode),
      .set_pos  (set_pos),
      .blink_en (blink_en),
      .seg_out  (seg_out),
      .dp_out   (dp_out),
      .dig_sel  (dig_sel),
      .busy     (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Common-anode (active-low) glyphs, {g,f,e,d,c,b,a}.
   function automatic logic [6:0] seg_ref(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [5:0] sel_ref(input int k);
      logic [5:0] one;
      one = 6'd1;
      return ~(one << k);
   endfunction

   function automatic frame_t model(input int h, input int m, input int s,
                                    input logic md, input logic [2:0] sp, input logic bl);
      frame_t f;
      int     v, dg;
      logic   blank;
      for (int k = 0; k < 6; k++) begin
         v       = (k < 2) ? s : ((k < 4) ? m : h);
         dg      = (k % 2 == 0) ? (v % 10) : (v / 10);
         blank   = md && !bl && sp[k / 2];
         f.seg[k] = blank ? 7'h7F : seg_ref(dg);
         f.dp[k]  = blank ? 1'b1 : !((k == 2) || (k == 4));
      end
      return f;
   endfunction

   task automatic wait_drain();
      int g;
      g = 0;
      while (exp_q.size() != 0 && g < 400) begin
         @(negedge clk);
         g++;
      end
      if (exp_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain: frame still pending after %0d clks", g);
         exp_q.delete();
      end
   endtask

   task automatic apply(input int h, input int m, input int s,
                        input logic md, input logic [2:0] sp, input logic bl);
      @(negedge clk);
      hour_in  = 5'(h);
      min_in   = 6'(m);
      sec_in   = 6'(s);
      mode     = md;
      set_pos  = sp;
      blink_en = bl;
      repeat (25) @(negedge clk);
      exp_q.push_back(model(h, m, s, md, sp, bl));
      wait_drain();
   endtask

   task automatic wait_busy(input logic lvl, input int lim, output bit ok);
      int g;
      g = 0;
      while (busy !== lvl && g < lim) begin
         @(negedge clk);
         g++;
      end
      ok = (busy === lvl);
   endtask

   // Scan monitor: compares one complete scan, starting at a fresh index-0 dwell.
   initial begin : scan_mon
      frame_t     fr;
      logic [5:0] prev;
      bit         ok;
      int         g;
      forever begin
         @(negedge clk);
         if (exp_q.size() == 0 || !reset) continue;
         fr   = exp_q[0];
         ok   = 1'b0;
         g    = 0;
         prev = dig_sel;
         while (!ok && g < 200) begin
            @(negedge clk);
            g++;
            ok   = (dig_sel == sel_ref(0)) && (prev != dig_sel);
            prev = dig_sel;
         end
         check("scan_start", 32'(ok), 32'd1);
         if (ok) begin
            for (int k = 0; k < 6; k++) begin
               g = 0;
               while (dig_sel != sel_ref(k) && g < 30) begin
                  @(negedge clk);
                  g++;
               end
               check($sformatf("sel%0d", k), 32'(dig_sel), 32'(sel_ref(k)));
               check($sformatf("seg%0d", k), 32'(seg_out), 32'(fr.seg[k]));
               check($sformatf("dp%0d", k), 32'(dp_out), 32'(fr.dp[k]));
            end
         end
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
   end

   // Every completed conversion must hold busy for exactly 8 clocks.
   initial begin : busy_mon
      int cnt;
      cnt = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            cnt = 0;
         end else if (busy) begin
            if (cnt == 0) busy_rises++;
            cnt++;
         end else if (cnt != 0) begin
            check("busy_len", 32'(cnt), 32'd8);
            cnt = 0;
         end
      end
   end

   // Each digit select must dwell SCAN_DIV clocks.
   initial begin : dwell_mon
      logic [5:0] prev;
      int         run;
      prev = '1;
      run  = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            prev = '1;
            run  = 0;
         end else if (dig_sel == prev) begin
            run++;
         end else begin
            if (prev != 6'h3F) check("dwell", 32'(run), 32'(SCAN_DIV));
            prev = dig_sel;
            run  = 1;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      bit ok;
      int rises_before;
      hour_in  = '0;
      min_in   = '0;
      sec_in   = '0;
      mode     = 1'b0;
      set_pos  = '0;
      blink_en = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("rst_seg", 32'(seg_out), 32'h7F);
      check("rst_dp", 32'(dp_out), 32'd1);
      check("rst_sel", 32'(dig_sel), 32'h3F);
      check("rst_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;

      apply(0, 0, 0, 1'b0, 3'b000, 1'b0);
      check("no_conv_zero", 32'(busy_rises), 32'd0);

      apply(23, 59, 58, 1'b0, 3'b000, 1'b0);
      check("conv_count", 32'(busy_rises), 32'd1);

      apply(23, 59, 58, 1'b1, 3'b010, 1'b0);
      apply(23, 59, 58, 1'b1, 3'b010, 1'b1);
      apply(23, 59, 58, 1'b0, 3'b010, 1'b0);
      apply(23, 59, 58, 1'b1, 3'b101, 1'b0);

      // Input change mid-conversion: old snapshot completes, then a re-conversion.
      @(negedge clk);
      mode   = 1'b0;
      sec_in = 6'd10;
      wait_busy(1'b1, 20, ok);
      check("mid_busy_rise", 32'(ok), 32'd1);
      repeat (3) @(negedge clk);
      sec_in = 6'd11;
      wait_busy(1'b0, 20, ok);
      check("mid_busy_fall", 32'(ok), 32'd1);
      wait_busy(1'b1, 5, ok);
      check("mid_reconvert", 32'(ok), 32'd1);
      wait_busy(1'b0, 20, ok);
      repeat (5) @(negedge clk);
      exp_q.push_back(model(23, 59, 11, 1'b0, 3'b000, 1'b0));
      wait_drain();

      apply(31, 63, 0, 1'b0, 3'b000, 1'b0);

      for (int i = 0; i < 8; i++) begin
         apply(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
               int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end

      // Reset during SHIFT aborts the conversion without touching the digits.
      @(negedge clk);
      mode    = 1'b0;
      hour_in = 5'd7;
      min_in  = 6'd45;
      sec_in  = 6'd33;
      wait_busy(1'b1, 20, ok);
      check("abort_busy_rise", 32'(ok), 32'd1);
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      hour_in = '0;
      min_in  = '0;
      sec_in  = '0;
      #1;
      check("abort_seg", 32'(seg_out), 32'h7F);
      check("abort_dp", 32'(dp_out), 32'd1);
      check("abort_sel", 32'(dig_sel), 32'h3F);
      check("abort_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      rises_before = busy_rises;
      reset = 1'b1;
      repeat (30) @(negedge clk);
      check("abort_no_conv", 32'(busy_rises), 32'(rises_before));
      exp_q.push_back(model(0, 0, 0, 1'b0, 3'b000, 1'b0));
      wait_drain();

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
